pwm_demod: RTL and testbench
============================

PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of the period and high-time counters and outputs.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port pwm_in, input, 1, asynchronous PWM bitstream, as produced by the team's PWM audio generator.
REQ-005 SHALL have port period, output, CNT_W, clk cycles from the previous pwm rising edge to the latest one.
REQ-006 SHALL have port high_time, output, CNT_W, clk cycles pwm was high within that period.
REQ-007 SHALL have port valid, output, 1, a measurement is held on period/high_time.
REQ-008 SHALL have port ready, input, 1, consumer accepts the measurement when valid && ready.
REQ-009 SHALL have port overrun, output, 1, sticky: an unaccepted measurement was overwritten.
REQ-010 SHALL have port stuck, output, 1, no pwm rising edge for 2^CNT_W-1 cycles.
REQ-011 SHALL have port stuck_level, output, 1, synchronized pwm level while stuck (0 = 0% duty, 1 = 100% duty).

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer (pwm_s) plus a delay flop (pwm_d); rise = pwm_s & ~pwm_d, fall = ~pwm_s & pwm_d.
REQ-013 SHALL implement states IDLE, HIGH, LOW, STUCK.
REQ-014 IDLE: wait for rise -> HIGH, counters loaded to 1; no measurement published on this first rise.
REQ-015 HIGH: period_cnt and high_cnt increment each cycle; fall -> LOW, high_cnt frozen.
REQ-016 LOW: period_cnt increments each cycle; rise -> publish period=period_cnt, high_time=high_cnt, then reload both to 1, stay in the new frame -> HIGH.
REQ-017 A rise while in HIGH (glitch-free input makes it impossible) SHALL be treated as in LOW.
REQ-018 Publication SHALL be registered on the same clk edge as the rise detection: valid rises 3 clk edges after pwm_in is first sampled high (no filter).
REQ-019 valid SHALL stay high, with period/high_time stable, until a cycle with ready=1; it clears on that edge unless a new publication happens in the same cycle.
REQ-020 Publication while valid && !ready SHALL overwrite data, keep valid=1, and set overrun; publication coinciding with valid && ready SHALL load the new data with valid=1 and no overrun.
REQ-021 overrun SHALL clear only on rst.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and never wrap; when period_cnt reaches 2^CNT_W-1 in any of HIGH, LOW or IDLE, the FSM SHALL enter STUCK.
REQ-023 STUCK: stuck=1 and stuck_level=pwm_s each cycle; no publication; a rise -> HIGH with counters at 1, stuck=0 on that edge; the next full frame publishes normally.
REQ-024 IDLE SHALL also run period_cnt so that a constant input reports stuck after 2^CNT_W-1 cycles from reset.

Reset
REQ-025 On rst=1 at a clk edge: state=IDLE, synchronizer/delay flops=0, counters=0, period=0, high_time=0, valid=0, overrun=0, stuck=0, stuck_level=0.
REQ-026 rst mid-frame SHALL discard the partial measurement and any held valid data; the next published frame requires two rises after rst deasserts.

Configuration
REQ-027 Macro PWM_DEMOD_GLITCH_FILTER_EN defined: pwm_s SHALL be the registered 3-sample majority of the synchronizer output, rejecting single-cycle pulses and adding 2 cycles to every latency.
REQ-028 Macro absent: no filter, latency per REQ-018; counts identical for clean input in both builds.

Verification
REQ-029 Square wave, 4 clk high / 4 clk low, ready=1 -> second and later publications period=8, high_time=4, valid one cycle each.
REQ-030 Period 20, high 5, ready=0 for three frames -> valid stays 1, data = latest frame, overrun=1; ready=1 -> valid=0 next edge, overrun stays 1.
REQ-031 pwm_in held 0 after reset, CNT_W=12 -> stuck=1, stuck_level=0 after 4095 cycles; held 1 -> stuck_level=1; next frame of 10/3 cycles -> stuck=0, then period=10, high_time=3.
REQ-032 rst pulsed mid-HIGH -> all outputs 0 next edge; first publication only after two further rises.
REQ-033 Filter build: 1-cycle high glitch inside a 4/4 wave -> period=8, high_time=4 unchanged; non-filter build -> glitch measured as extra frame.

Source files
------------

// File: rtl/pwm_demod.sv
// PWM demodulator: measures period and high time of each pwm_in frame and hands them out with valid/ready.
// Optional build macro PWM_DEMOD_GLITCH_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module pwm_demod #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  logic [1:0]       sync_q, sync_d;
  logic             pwm_s;
  logic             pwm_d_q, pwm_d_d;
  logic             rise, fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;
  logic             publish;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    sync_d  = {sync_q[0], pwm_in};
    pwm_d_d = pwm_s;
  end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  // Majority over the current and two previous synchronized samples drops 1-cycle pulses.
  logic [1:0] hist_q, hist_d;
  logic       maj_q, maj_d;

  always_comb begin
    hist_d = {hist_q[0], sync_q[1]};
    maj_d  = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      maj_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      maj_q  <= maj_d;
    end
  end

  assign pwm_s = maj_q;
`else
  assign pwm_s = sync_q[1];
`endif

  assign rise = pwm_s & ~pwm_d_q;
  assign fall = ~pwm_s & pwm_d_q;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    publish      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d      = HIGH;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (period_cnt_d == CNT_MAX) state_d = STUCK;
        end
      end
      HIGH, LOW: begin
        // A rise is treated the same way from HIGH as from LOW: close the frame.
        if (rise) begin
          publish      = 1'b1;
          state_d      = HIGH;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (state_q == HIGH) begin
            if (fall) state_d = LOW;
            else      high_cnt_d = sat_inc(high_cnt_q);
          end
          if (period_cnt_d == CNT_MAX) state_d = STUCK;
        end
      end
      STUCK: begin
        if (rise) begin
          state_d      = HIGH;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (publish) begin
      period_d    = period_cnt_q;
      high_time_d = high_cnt_q;
      valid_d     = 1'b1;
      if (valid_q && !ready) overrun_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    stuck_d       = (state_d == STUCK);
    stuck_level_d = (state_d == STUCK) & pwm_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      pwm_d_q       <= 1'b0;
      state_q       <= IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      pwm_d_q       <= pwm_d_d;
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
  assign stuck       = stuck_q;
  assign stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: directed and random frames against a sample-domain frame model.
module tb_pwm_demod;
  localparam int W = 12;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  localparam bit FILT    = 1'b1;
  localparam int PUB_DLY = 3;
`else
  localparam bit FILT    = 1'b0;
  localparam int PUB_DLY = 2;
`endif

  logic         clk = 1'b0;
  logic         rst, pwm_in, ready;
  logic [W-1:0] period, high_time;
  logic         valid, overrun, stuck, stuck_level;

  pwm_demod #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period(period), .high_time(high_time), .valid(valid), .ready(ready),
    .overrun(overrun), .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame model in the input-sample domain: frames are spans between rises
  // of the (optionally majority-filtered) input, reported a fixed delay later.
  typedef struct { int due; int per; int hi; } pub_t;
  pub_t pq[$];
  int   n = 0;
  bit   h1, h2, m_prev, in_high;
  int   start = -1;
  int   high_run;
  bit   e_valid, e_ovr;
  int   e_per, e_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit pin, input bit rdy, input bit r);
    bit   m, rise;
    pub_t p;
    if (r) begin
      h1 = 0; h2 = 0; m_prev = 0; in_high = 0; start = -1; high_run = 0;
      pq.delete();
      e_valid = 0; e_ovr = 0; e_per = 0; e_hi = 0;
    end else begin
      m = FILT ? ((pin & h1) | (pin & h2) | (h1 & h2)) : pin;
      h2 = h1; h1 = pin;
      rise = m & !m_prev;
      m_prev = m;
      if (rise) begin
        if (start >= 0) begin
          p.due = n + PUB_DLY; p.per = n - start; p.hi = high_run;
          pq.push_back(p);
        end
        start = n; high_run = 1; in_high = 1;
      end else if (start >= 0) begin
        if (in_high && m) high_run++;
        else in_high = 0;
        if (n - start >= 4095) start = -1;  // frame too long: lost to saturation
      end
      if (pq.size() > 0 && pq[0].due == n) begin
        p = pq.pop_front();
        if (e_valid && !rdy) e_ovr = 1;
        e_valid = 1; e_per = p.per; e_hi = p.hi;
      end else if (e_valid && rdy) begin
        e_valid = 0;
      end
    end
    n++;
  endtask

  task automatic cyc(input bit pin, input bit rdy, input bit r);
    pwm_in = pin; ready = rdy; rst = r;
    @(posedge clk);
    model_edge(pin, rdy, r);
    @(negedge clk);
    chk("valid", valid, e_valid);
    chk("overrun", overrun, e_ovr);
    chk("period", period, e_per);
    chk("high_time", high_time, e_hi);
  endtask

  task automatic frame(input int hi, input int lo, input bit rnd, input bit rdy);
    for (int i = 0; i < hi; i++) cyc(1'b1, rnd ? 1'($urandom_range(0, 1)) : rdy, 1'b0);
    for (int i = 0; i < lo; i++) cyc(1'b0, rnd ? 1'($urandom_range(0, 1)) : rdy, 1'b0);
  endtask

  initial begin
    pwm_in = 0; ready = 0; rst = 1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_valid", valid, 0);
    chk("rst_period", period, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_stuck_level", stuck_level, 0);
    cyc(0, 1, 0);

    // 4/4 square wave, always ready
    for (int i = 0; i < 6; i++) frame(4, 4, 0, 1);
    chk("sq_period", period, 8);
    chk("sq_high", high_time, 4);

    // single-cycle glitch inside the low phase
    frame(4, 1, 0, 1);
    frame(1, 2, 0, 1);
    for (int i = 0; i < 3; i++) frame(4, 4, 0, 1);
    chk("glitch_period", period, 8);
    chk("glitch_high", high_time, 4);

    // consumer stalls for several 20/5 frames
    for (int i = 0; i < 4; i++) frame(5, 15, 0, 0);
    chk("stall_valid", valid, 1);
    chk("stall_overrun", overrun, 1);
    chk("stall_period", period, 20);
    chk("stall_high", high_time, 5);
    cyc(0, 1, 0);
    chk("drain_valid", valid, 0);
    chk("drain_overrun", overrun, 1);

    // reset in the middle of a high phase
    frame(4, 4, 0, 1);
    frame(4, 4, 0, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    chk("mrst_valid", valid, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_period", period, 0);
    chk("mrst_high", high_time, 0);
    frame(2, 6, 0, 1);
    chk("mrst_nopub_valid", valid, 0);
    chk("mrst_nopub_period", period, 0);
    frame(4, 4, 0, 1);
    frame(4, 4, 0, 1);

    // random frames with a random consumer
    for (int i = 0; i < 60; i++)
      frame($urandom_range(3, 12), $urandom_range(3, 12), 1, 0);

    // constant input after reset -> stuck
    cyc(0, 1, 1);
    repeat (4094) cyc(0, 1, 0);
    chk("stuck_before", stuck, 0);
    cyc(0, 1, 0);
    chk("stuck_low", stuck, 1);
    chk("stuck_low_level", stuck_level, 0);
    repeat (4200) cyc(1, 1, 0);
    chk("stuck_high", stuck, 1);
    chk("stuck_high_level", stuck_level, 1);
    repeat (6) cyc(0, 1, 0);
    chk("stuck_relow", stuck, 1);
    chk("stuck_relow_level", stuck_level, 0);
    frame(3, 7, 0, 1);
    chk("stuck_exit", stuck, 0);
    frame(3, 7, 0, 1);
    chk("stuck_after_period", period, 10);
    chk("stuck_after_high", high_time, 3);
    chk("stuck_after_stuck", stuck, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
